// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its buffer.
package fetch_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int BUF_DEPTH   = 2;
    localparam int ENTRY_W     = 64;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {word, pc} between the fetch PC and decode; flush beats push and pop.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    fetch_entry_t mem [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && !empty;
    // When full, wr_ptr == rd_ptr: a same-cycle push overwrites the slot being popped.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == 2'(BUF_DEPTH));
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, feeds a 2-entry buffer, handles redirects.
// Define FETCH_BOUND_CHECK_EN to halt with FAULT on a fetch beyond MEM_BYTES.
//
// state    | meaning
// ST_IDLE  | no fetch, waiting for START or REDIRECT
// ST_FETCH | fetching whenever the buffer can take a word
// ST_HALT  | out-of-range PC seen; buffer drains, leave via REDIRECT or RST
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_dir,
    input  logic [31:0] imem_do,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        busy,
    output logic        fault
);
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         fault_r;
    logic         buf_full;
    logic         buf_empty;
    logic         pop;
    logic         push;
    logic         out_of_range;
    fetch_entry_t head;
    fetch_entry_t din;

    assign out_of_range = CHECK_EN && (pc > LAST_PC);
    assign pop          = !buf_empty && inst_ready && !redirect;
    assign push         = (state == ST_FETCH) && !redirect && !out_of_range && (!buf_full || pop);
    assign din          = '{word: imem_do, pc: pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            fault_r <= 1'b0;
        end else if (redirect) begin
            state   <= ST_FETCH;
            pc      <= {redirect_pc[31:2], 2'b00};
            fault_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= RESET_PC;
                    end
                end
                ST_FETCH: begin
                    if (out_of_range) begin
                        fault_r <= 1'b1;
                        state   <= ST_HALT;
                    end else if (push) begin
                        pc <= pc + 32'(INSTR_BYTES);
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (head)
    );

    assign imem_dir   = pc;
    assign inst_valid = !buf_empty;
    assign inst       = head.word;
    assign inst_pc    = head.pc;
    assign busy       = (state != ST_IDLE);
    assign fault      = fault_r;
endmodule
